// File: rtl/mc_datapath_mul_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_datapath_mul_if : controller/memory bus bundle for mc_datapath_mul
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
interface mc_datapath_mul_if #(
  parameter int WIDTH = 32
);
  logic             MemReady;
  logic [WIDTH-1:0] ReadData;
  logic [WIDTH-1:0] Adr;
  logic [WIDTH-1:0] WriteData;
  logic [31:0]      Instr;
  logic [3:0]       ALUFlags;
  logic             PCWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]       RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic             MulStart, MulBusy, MulDone;

  modport master (
    output MemReady, ReadData, PCWrite, RegWrite, IRWrite, AdrSrc,
    output RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, MulStart,
    input  Adr, WriteData, Instr, ALUFlags, MulBusy, MulDone
  );

  modport slave (
    input  MemReady, ReadData, PCWrite, RegWrite, IRWrite, AdrSrc,
    input  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, MulStart,
    output Adr, WriteData, Instr, ALUFlags, MulBusy, MulDone
  );
endinterface
`default_nettype wire

// File: rtl/mc_datapath_mul.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_datapath_mul : parametrised multicycle ARM-subset datapath with an
//                   optional iterative shift-add multiplier (MC_DP_MUL_EN)
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module mc_datapath_mul #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  mc_datapath_mul_if.slave dp
);

  logic [WIDTH-1:0] pc_q, data_q, a_q, wd_q, aluout_q, aluout_d;
  logic [31:0]      ir_q;
  logic [WIDTH-1:0] rf_q [16];

  logic [3:0]       ra1, ra2;
  logic [WIDTH-1:0] rd1, rd2, result, src_a, src_b, ext_imm, b_eff, alu_result;
  logic [WIDTH:0]   sum;
  logic [25:0]      br_imm;
  logic [WIDTH-1:0] br_ext;
  logic             c_flag, v_flag;

  assign ra1 = dp.RegSrc[0] ? 4'd15 : ir_q[19:16];
  assign ra2 = dp.RegSrc[1] ? ir_q[15:12] : ir_q[3:0];
  // R15 is never stored; reading it yields the live Result
  assign rd1 = (ra1 == 4'd15) ? result : rf_q[ra1];
  assign rd2 = (ra2 == 4'd15) ? result : rf_q[ra2];

  assign br_imm = {ir_q[23:0], 2'b00};
  generate
    if (WIDTH > 26) begin : g_br_sext
      assign br_ext = {{(WIDTH-26){br_imm[25]}}, br_imm};
    end else begin : g_br_trunc
      assign br_ext = br_imm[WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    case (dp.ImmSrc)
      2'b00:   ext_imm = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
      2'b01:   ext_imm = {{(WIDTH-12){1'b0}}, ir_q[11:0]};
      2'b10:   ext_imm = br_ext;
      default: ext_imm = '0;
    endcase
  end

  always_comb begin
    case (dp.ALUSrcA)
      2'b00:   src_a = a_q;
      2'b01:   src_a = pc_q;
      default: src_a = '0;
    endcase
    case (dp.ALUSrcB)
      2'b00:   src_b = wd_q;
      2'b01:   src_b = ext_imm;
      2'b10:   src_b = WIDTH'(4);
      default: src_b = '0;
    endcase
  end

  always_comb begin
    b_eff  = (dp.ALUControl == 2'b01) ? ~src_b : src_b;
    sum    = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (dp.ALUControl == 2'b01)};
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (dp.ALUControl)
      2'b10:   alu_result = src_a & src_b;
      2'b11:   alu_result = src_a | src_b;
      default: begin
        alu_result = sum[WIDTH-1:0];
        c_flag     = sum[WIDTH];
        v_flag     = (src_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
    endcase
  end

  always_comb begin
    case (dp.ResultSrc)
      2'b01:   result = data_q;
      2'b10:   result = alu_result;
      default: result = aluout_q;
    endcase
  end

  assign dp.ALUFlags  = {alu_result[WIDTH-1], (alu_result == '0), c_flag, v_flag};
  assign dp.Adr       = dp.AdrSrc ? aluout_q : pc_q;
  assign dp.WriteData = wd_q;
  assign dp.Instr     = ir_q;

`ifdef MC_DP_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  mul_state_t       state_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        MUL_IDLE: if (dp.MulStart) begin
          state_q  <= MUL_RUN;
          mcand_q  <= a_q;
          mplier_q <= wd_q;
          acc_q    <= '0;
          cnt_q    <= CW'(WIDTH);
          busy_q   <= 1'b1;
        end
        MUL_RUN: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          // the step that takes the count to zero is the last accumulation
          if (cnt_q == CW'(1)) begin
            state_q <= MUL_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= MUL_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dp.MulBusy = busy_q;
  assign dp.MulDone = done_q;
  assign aluout_d   = done_q ? acc_q : alu_result;
`else
  logic unused_mulstart;
  assign unused_mulstart = dp.MulStart;
  assign dp.MulBusy      = 1'b0;
  assign dp.MulDone      = 1'b0;
  assign aluout_d        = alu_result;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      data_q   <= '0;
      a_q      <= '0;
      wd_q     <= '0;
      aluout_q <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      if (dp.PCWrite) pc_q <= result;
      if (dp.IRWrite && dp.MemReady) ir_q <= 32'(dp.ReadData);
      if (dp.MemReady) data_q <= dp.ReadData;
      a_q      <= rd1;
      wd_q     <= rd2;
      aluout_q <= aluout_d;
      if (dp.RegWrite && (ir_q[15:12] != 4'd15)) rf_q[ir_q[15:12]] <= result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath_mul.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mc_datapath_mul : scoreboard bench for mc_datapath_mul
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mc_datapath_mul;
  localparam int          WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_datapath_mul_if #(.WIDTH(WIDTH)) dp ();
  mc_datapath_mul #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] last_r1 = '0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check(t, obs, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    dp.MemReady = 0; dp.ReadData = '0; dp.PCWrite = 0; dp.RegWrite = 0;
    dp.IRWrite = 0; dp.AdrSrc = 0; dp.RegSrc = 0; dp.ALUSrcA = 0;
    dp.ALUSrcB = 0; dp.ResultSrc = 0; dp.ImmSrc = 0; dp.ALUControl = 0;
    dp.MulStart = 0;
  endtask

  task automatic fetch(input logic [31:0] w);
    dp.PCWrite = 0; dp.RegWrite = 0;
    dp.MemReady = 1; dp.IRWrite = 1; dp.ReadData = w;
    step();
    dp.MemReady = 0; dp.IRWrite = 0;
  endtask

  // Needs Instr[15:12]=1: b goes through Data into R1 (read as RA2), a into A via RA1=15.
  task automatic load_ops(input logic [31:0] a, input logic [31:0] b);
    dp.PCWrite = 0; dp.IRWrite = 0; dp.RegWrite = 0;
    dp.RegSrc = 2'b11; dp.ResultSrc = 2'b01;
    dp.MemReady = 1; dp.ReadData = b; step();
    dp.MemReady = 0; dp.RegWrite = 1; step();
    dp.RegWrite = 0; dp.MemReady = 1; dp.ReadData = a; step();
    dp.MemReady = 0; step();
    last_r1 = b;
    check("ld_wdata", dp.WriteData, b);
  endtask

  task automatic alu_model(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic [3:0] fl);
    longint unsigned u;
    longint          sr;
    logic            c, v;
    c = 0; v = 0;
    case (ctl)
      2'd0: begin
        u   = 64'(a) + 64'(b);
        res = u[31:0];
        c   = (u > 64'hFFFF_FFFF);
        sr  = longint'($signed(a)) + longint'($signed(b));
        v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'd1: begin
        res = a - b;
        c   = (a >= b);
        sr  = longint'($signed(a)) - longint'($signed(b));
        v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'd2:    res = a & b;
      default: res = a | b;
    endcase
    fl = {res[31], (res == 32'd0), c, v};
  endtask

  task automatic alu_op(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] res;
    logic [3:0]  fl;
    load_ops(a, b);
    alu_model(ctl, a, b, res, fl);
    sb_push({tag, "_flags"}, {28'd0, fl});
    sb_push({tag, "_res"}, res);
    dp.ALUSrcA = 2'b00; dp.ALUSrcB = 2'b00; dp.ALUControl = ctl; dp.AdrSrc = 1;
    #1;
    sb_pop({28'd0, dp.ALUFlags});
    step();
    sb_pop(dp.Adr);
    dp.AdrSrc = 0;
  endtask

`ifdef MC_DP_MUL_EN
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string tag,
                         input bit interfere);
    int t0;
    load_ops(a, b);
    sb_push(tag, 32'(64'(a) * 64'(b)));
    dp.AdrSrc = 0; dp.MulStart = 1; step(); t0 = cyc; dp.MulStart = 0;
    check({tag, "_busy"}, {31'd0, dp.MulBusy}, 32'd1);
    if (interfere) begin
      repeat (3) step();
      load_ops(32'd3, 32'd3);
      dp.MulStart = 1; step(); dp.MulStart = 0;
    end
    while (dp.MulDone !== 1'b1 && (cyc - t0) < 4 * WIDTH) step();
    // MulDone is visible right after edge t+WIDTH
    check({tag, "_lat"}, 32'(cyc - t0), 32'(WIDTH));
    dp.AdrSrc = 1; dp.MulStart = 1; step(); dp.MulStart = 0;
    sb_pop(dp.Adr);
    check({tag, "_busy_fall"}, {31'd0, dp.MulBusy}, 32'd0);
    step();
    check({tag, "_restart_ignored"}, {31'd0, dp.MulBusy}, 32'd0);
    dp.AdrSrc = 0;
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    idle();
    reset = 1; dp.AdrSrc = 1;
    step(); step();
    check("rst_aluout", dp.Adr, 32'd0);
    check("rst_wdata", dp.WriteData, 32'd0);
    check("rst_instr", dp.Instr, 32'd0);
    check("rst_busy", {31'd0, dp.MulBusy}, 32'd0);
    check("rst_done", {31'd0, dp.MulDone}, 32'd0);
    dp.AdrSrc = 0; #1;
    check("rst_pc", dp.Adr, RESET_PC);
    reset = 0;
    step();
    check("pc_hold", dp.Adr, RESET_PC);

    // fetch stalled by MemReady, then PC+4
    dp.ReadData = 32'hE281_1005; dp.IRWrite = 1; dp.MemReady = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fetch_stall", dp.Instr, 32'd0);
    end
    sb_push("fetch_ir", 32'hE281_1005);
    sb_push("pc_plus4", RESET_PC + 32'd4);
    dp.MemReady = 1; dp.PCWrite = 1; dp.ALUSrcA = 2'b01; dp.ALUSrcB = 2'b10; dp.ResultSrc = 2'b10;
    step();
    sb_pop(dp.Instr);
    sb_pop(dp.Adr);
    dp.MemReady = 0; dp.ReadData = 32'hDEAD_BEEF; dp.ResultSrc = 2'b01;
    step();
    check("ir_hold", dp.Instr, 32'hE281_1005);
    check("data_to_pc", dp.Adr, 32'hE281_1005);
    idle();

    alu_op(2'd1, 32'd5, 32'd5, "sub_eq");
    alu_op(2'd0, 32'h7FFF_FFFF, 32'd1, "add_ovf");
    alu_op(2'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, "and_zero");
    alu_op(2'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, "orr");
    alu_op(2'd0, 32'hFFFF_FFFF, 32'd5, "add_carry");
    alu_op(2'd1, 32'd3, 32'd5, "sub_neg");
    alu_op(2'd1, 32'h8000_0000, 32'd1, "sub_ovf");

    // immediate extension with SrcA forced to zero
    fetch(32'hE2A1_1ABC);
    dp.ALUSrcA = 2'b10; dp.ALUSrcB = 2'b01; dp.ALUControl = 2'b00; dp.AdrSrc = 1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] imm_tab [4];
      imm_tab[0] = 32'h0000_00BC; imm_tab[1] = 32'h0000_0ABC;
      imm_tab[2] = 32'hFE84_6AF0; imm_tab[3] = 32'h0000_0000;
      dp.ImmSrc = 2'(k);
      sb_push($sformatf("imm_src%0d", k), imm_tab[k]);
      step();
      sb_pop(dp.Adr);
    end
    idle();

    // write R1 while reading it: A must see the old value first
    dp.MemReady = 1; dp.ReadData = 32'h1357_9BDF; dp.ResultSrc = 2'b01; step();
    dp.MemReady = 0; dp.RegSrc = 2'b00; dp.RegWrite = 1;
    dp.ALUSrcA = 2'b00; dp.ALUSrcB = 2'b11; dp.AdrSrc = 1;
    sb_push("rf_old_read", last_r1);
    sb_push("rf_new_read", 32'h1357_9BDF);
    step();
    dp.RegWrite = 0; step();
    sb_pop(dp.Adr);
    step();
    sb_pop(dp.Adr);
    last_r1 = 32'h1357_9BDF;
    idle();

`ifdef MC_DP_MUL_EN
    fetch(32'hE281_1005);
    run_mul(32'd7, 32'd6, "mul_7x6", 1'b1);

    load_ops(32'd12345, 32'd678);
    dp.MulStart = 1; step(); dp.MulStart = 0;
    repeat (9) step();
    reset = 1; step(); reset = 0;
    check("abort_busy", {31'd0, dp.MulBusy}, 32'd0);
    check("abort_pc", dp.Adr, RESET_PC);
    saw = 0;
    repeat (WIDTH + 8) begin
      step();
      saw = saw | dp.MulDone | dp.MulBusy;
    end
    check("abort_quiet", {31'd0, saw}, 32'd0);
    last_r1 = '0;

    fetch(32'hE281_1005);
    run_mul(32'hFFFF_FFFF, 32'd2, "mul_wrap", 1'b0);
`else
    load_ops(32'd7, 32'd6);
    dp.MulStart = 1; step(); dp.MulStart = 0;
    saw = 0;
    repeat (WIDTH + 4) begin
      step();
      saw = saw | dp.MulDone | dp.MulBusy;
    end
    check("nomul_quiet", {31'd0, saw}, 32'd0);
    dp.ALUSrcA = 2'b00; dp.ALUSrcB = 2'b00; dp.ALUControl = 2'b00; dp.AdrSrc = 1;
    sb_push("nomul_aluout", 32'd13);
    step();
    sb_pop(dp.Adr);
    idle();
`endif

    // R15 write is dropped; R15 reads return Result
    fetch(32'hE281_F005);
    dp.RegSrc = 2'b00; dp.ResultSrc = 2'b01; dp.RegWrite = 1;
    dp.ALUSrcA = 2'b00; dp.ALUSrcB = 2'b11; dp.ALUControl = 2'b00; dp.AdrSrc = 1;
    step();
    dp.RegWrite = 0; step();
    check("r15_r1_kept", dp.Adr, last_r1);
    check("r15_r5_kept", dp.WriteData, 32'd0);
    dp.RegSrc = 2'b11; step();
    check("r15_rd2_result", dp.WriteData, 32'hE281_F005);
    step();
    check("r15_rd1_result", dp.Adr, 32'hE281_F005);
    idle();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
